// File: rtl/mem_lsu_pipelined_if.sv
// Bundle of MEM-stage request, SRAM-like data bus and write-back response signals
// for the pipelined load/store unit.
interface mem_lsu_pipelined_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  req_valid;
  logic [2:0]            req_op;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic [REG_ADDR_W-1:0] req_wd;
  logic [31:0]           req_pc;
  logic                  req_ready;
  logic                  mem_stall;
  logic                  flush;
  logic                  data_req;
  logic                  data_wr;
  logic [1:0]            data_size;
  logic [31:0]           data_addr;
  logic [31:0]           data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [31:0]           data_rdata;
  logic                  resp_valid;
  logic                  resp_wreg;
  logic [REG_ADDR_W-1:0] resp_wd;
  logic [31:0]           resp_wdata;
  logic [31:0]           resp_pc;
  logic                  addr_err;
  logic                  addr_err_st;
  logic [31:0]           badvaddr;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_wd, req_pc, flush,
    input  data_addr_ok, data_data_ok, data_rdata,
    output req_ready, mem_stall, data_req, data_wr, data_size, data_addr, data_wdata,
    output resp_valid, resp_wreg, resp_wd, resp_wdata, resp_pc,
    output addr_err, addr_err_st, badvaddr
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_wd, req_pc, flush,
    output data_addr_ok, data_data_ok, data_rdata,
    input  req_ready, mem_stall, data_req, data_wr, data_size, data_addr, data_wdata,
    input  resp_valid, resp_wreg, resp_wd, resp_wdata, resp_pc,
    input  addr_err, addr_err_st, badvaddr
  );
endinterface

// File: rtl/mem_lsu_pipelined.sv
// Pipelined MEM-stage load/store unit: in-order tracker of up to MAX_OUTSTANDING bus
// transactions, alignment faults, store lane replication and load extension.
module mem_lsu_pipelined #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int REG_ADDR_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  mem_lsu_pipelined_if.slave bus
);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] lo,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lo, 3'b000} +: 8];
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      3'd0:    load_extend = {{24{b[7]}}, b};
      3'd1:    load_extend = {24'h000000, b};
      3'd2:    load_extend = {{16{h[15]}}, h};
      3'd3:    load_extend = {16'h0000, h};
      3'd4:    load_extend = rdata;
      default: load_extend = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] store_format(input logic [2:0] op, input logic [31:0] wdata);
    case (op)
      3'd5:    store_format = {4{wdata[7:0]}};
      3'd6:    store_format = {2{wdata[15:0]}};
      default: store_format = wdata;
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    ptr_next = (p == LAST_PTR) ? {PTR_W{1'b0}} : p + 1'b1;
  endfunction

  logic [2:0]            op_r     [MAX_OUTSTANDING];
  logic [1:0]            lo_r     [MAX_OUTSTANDING];
  logic [REG_ADDR_W-1:0] wd_r     [MAX_OUTSTANDING];
  logic [31:0]           pc_r     [MAX_OUTSTANDING];
  logic                  wr_r     [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] squash_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;

  logic       half_s;
  logic       word_s;
  logic [1:0] size_s;
  logic       misalign_s;
  logic       is_store_s;
  logic       issue_s;
  logic       push_s;
  logic       pop_s;
  logic       addr_err_s;
  logic       resp_valid_s;

  // Access width decode from the opcode.
  always_comb begin
    half_s = 1'b0;
    word_s = 1'b0;
    size_s = 2'd0;
    case (bus.req_op)
      3'd2, 3'd3, 3'd6: begin
        half_s = 1'b1;
        size_s = 2'd1;
      end
      3'd4, 3'd7: begin
        word_s = 1'b1;
        size_s = 2'd2;
      end
      default: begin
        half_s = 1'b0;
        word_s = 1'b0;
        size_s = 2'd0;
      end
    endcase
  end

  assign misalign_s = (half_s & bus.req_addr[0]) | (word_s & (bus.req_addr[1:0] != 2'b00));
  assign is_store_s = bus.req_op[2] & (bus.req_op != 3'd4);
  // Full uses the registered count so a same-cycle pop cannot open a slot.
  assign issue_s    = ~rst & bus.req_valid & ~misalign_s & (count_r != FULL_CNT) & ~bus.flush;
  assign push_s     = issue_s & bus.data_addr_ok;
  assign pop_s      = ~rst & bus.data_data_ok & (count_r != {CNT_W{1'b0}});
  assign addr_err_s = ~rst & bus.req_valid & misalign_s;
  assign resp_valid_s = pop_s & ~squash_r[rd_ptr_r];

  assign bus.data_req    = issue_s;
  assign bus.data_wr     = ~rst & is_store_s;
  assign bus.data_size   = rst ? 2'd0 : size_s;
  assign bus.data_addr   = rst ? 32'h0000_0000 : {3'b000, bus.req_addr[28:0]};
  assign bus.data_wdata  = rst ? 32'h0000_0000 : store_format(bus.req_op, bus.req_wdata);
  assign bus.req_ready   = ~rst & bus.req_valid & (misalign_s | push_s);
  assign bus.mem_stall   = ~rst & bus.req_valid & ~bus.req_ready;
  assign bus.addr_err    = addr_err_s;
  assign bus.addr_err_st = addr_err_s & is_store_s;
  assign bus.badvaddr    = addr_err_s ? bus.req_addr : 32'h0000_0000;

  assign bus.resp_valid  = resp_valid_s;
  assign bus.resp_wreg   = resp_valid_s & ~wr_r[rd_ptr_r];
  assign bus.resp_wd     = resp_valid_s ? wd_r[rd_ptr_r] : {REG_ADDR_W{1'b0}};
  assign bus.resp_pc     = resp_valid_s ? pc_r[rd_ptr_r] : 32'h0000_0000;
  assign bus.resp_wdata  = resp_valid_s ?
                           load_extend(op_r[rd_ptr_r], lo_r[rd_ptr_r], bus.data_rdata) :
                           32'h0000_0000;

  // Tracker FIFO: entry capture on push, pointer/count bookkeeping, flush squash.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        op_r[i] <= 3'd0;
        lo_r[i] <= 2'd0;
        wd_r[i] <= {REG_ADDR_W{1'b0}};
        pc_r[i] <= 32'h0000_0000;
        wr_r[i] <= 1'b0;
      end
      squash_r <= {MAX_OUTSTANDING{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        op_r[wr_ptr_r]     <= bus.req_op;
        lo_r[wr_ptr_r]     <= bus.req_addr[1:0];
        wd_r[wr_ptr_r]     <= bus.req_wd;
        pc_r[wr_ptr_r]     <= bus.req_pc;
        wr_r[wr_ptr_r]     <= is_store_s;
        squash_r[wr_ptr_r] <= 1'b0;
        wr_ptr_r           <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      // Push never coincides with flush, so marking every slot is safe.
      if (bus.flush) begin
        squash_r <= {MAX_OUTSTANDING{1'b1}};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule
